inv_seq_ctrl: RTL and testbench

Sequencer for the 5x5 rational matrix-inverse datapath.
- Accepts a 25-element job over a valid/ready load stream and writes it into the datapath matrix store.
- Kicks the datapath and waits for completion, bounded by a timeout.
- Reads back the 25 numerator/denominator result pairs by address and streams them out over a valid/ready result port.
- Sits between the host-side bus adapter and the inverse datapath; it is the only master of the datapath address bus.

---
 rtl/inv_pkg.sv | 27 ++
 rtl/inv_result_reg.sv | 41 ++++
 rtl/inv_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_inv_seq_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_pkg.sv
// Shared definitions for the 5x5 rational matrix-inverse sequencer.
package inv_pkg;

    localparam int N           = 5;
    localparam int DW          = 32;
    localparam int AW          = 5;
    localparam int NELEM       = N * N;
    localparam int LAST_IDX    = NELEM - 1;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_RADDR,
        S_RCAP,
        S_OUT,
        S_FIN
    } state_t;

    // True when the element index addresses the final matrix element.
    function automatic logic is_last(input logic [AW-1:0] idx);
        return idx == AW'(LAST_IDX);
    endfunction

endpackage

// File: rtl/inv_result_reg.sv
// Result payload register: captures one numerator/denominator pair and
// holds it, with valid raised, until the consumer accepts it.
module inv_result_reg
    import inv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic [DW-1:0] num_in,
    input  logic [DW-1:0] den_in,
    input  logic [AW-1:0] index_in,
    input  logic          last_in,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] num,
    output logic [DW-1:0] den,
    output logic [AW-1:0] index,
    output logic          last
);

    // Load payload on capture; drop valid after the accepting handshake,
    // payload bits stay put so a late observer never sees a glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            num   <= '0;
            den   <= '0;
            index <= '0;
            last  <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            num   <= num_in;
            den   <= den_in;
            index <= index_in;
            last  <= last_in;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inv_seq_ctrl.sv
// Sequencer for the matrix-inverse datapath: loads a job, kicks the
// datapath, waits (bounded) for completion, then streams the results.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no job; waits for start
//   LOAD   | accepts 25 elements, writes each into the matrix store
//   KICK   | one-cycle datapath start pulse
//   WAIT   | waits for dp_done, gives up after TIMEOUT cycles
//   RADDR  | drives the read address of the current result
//   RCAP   | read data valid; captured into the result register
//   OUT    | result offered on the output port until accepted
//   FIN    | one-cycle done pulse, then back to IDLE
module inv_seq_ctrl
    import inv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [DW-1:0] load_data,
    output logic          dp_wr_en,
    output logic [AW-1:0] dp_addr,
    output logic [DW-1:0] dp_wdata,
    output logic          dp_start,
    input  logic          dp_done,
    input  logic [DW-1:0] dp_rd_num,
    input  logic [DW-1:0] dp_rd_den,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_num,
    output logic [DW-1:0] out_den,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic          done,
    output logic          singular,
    output logic          timeout_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    logic [AW-1:0] idx;
    logic [TW-1:0] timer;
    logic [AW-1:0] dp_addr_q;

    // Write strobe follows the load handshake in the same cycle.
    assign dp_wr_en = load_ready && load_valid;
    assign dp_wdata = dp_wr_en ? load_data : '0;

    // Address is live from idx while loading or issuing a read, and
    // otherwise holds whatever was last driven.
    assign dp_addr = (state == S_LOAD || state == S_RADDR) ? idx : dp_addr_q;

    // Sequencer state, counters, sticky flags and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            timer       <= '0;
            dp_addr_q   <= '0;
            busy        <= 1'b0;
            load_ready  <= 1'b0;
            dp_start    <= 1'b0;
            done        <= 1'b0;
            singular    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            dp_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        singular    <= 1'b0;
                        timeout_err <= 1'b0;
                        idx         <= '0;
                        busy        <= 1'b1;
                        load_ready  <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        dp_addr_q <= idx;
                        if (is_last(idx)) begin
                            load_ready <= 1'b0;
                            dp_start   <= 1'b1;
                            state      <= S_KICK;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                S_KICK: begin
                    timer <= '0;
                    idx   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    // Completion wins over a timeout landing in the same cycle.
                    if (dp_done) begin
                        state <= S_RADDR;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_FIN;
                    end
                end
                S_RADDR: begin
                    dp_addr_q <= idx;
                    state     <= S_RCAP;
                end
                S_RCAP: begin
                    if (dp_rd_den == '0) begin
                        singular <= 1'b1;
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (out_valid && out_ready) begin
                        if (is_last(idx)) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            idx   <= idx + AW'(1);
                            state <= S_RADDR;
                        end
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    load_ready <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    inv_result_reg u_result (
        .clk      (clk),
        .rst_n    (reset),
        .capture  (state == S_RCAP),
        .num_in   (dp_rd_num),
        .den_in   (dp_rd_den),
        .index_in (idx),
        .last_in  (is_last(idx)),
        .ready    (out_ready),
        .valid    (out_valid),
        .num      (out_num),
        .den      (out_den),
        .index    (out_index),
        .last     (out_last)
    );

endmodule

// File: tb/tb_inv_seq_ctrl.sv
// Directed bench for inv_seq_ctrl with a behavioural datapath model.
module tb_inv_seq_ctrl;
    import inv_pkg::*;

    localparam int TMO = 1024;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_data;
    logic          dp_wr_en;
    logic [AW-1:0] dp_addr;
    logic [DW-1:0] dp_wdata;
    logic          dp_start;
    logic          dp_done;
    logic [DW-1:0] dp_rd_num;
    logic [DW-1:0] dp_rd_den;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_num;
    logic [DW-1:0] out_den;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          done;
    logic          singular;
    logic          timeout_err;

    inv_seq_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .dp_wr_en(dp_wr_en), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .dp_start(dp_start), .dp_done(dp_done),
        .dp_rd_num(dp_rd_num), .dp_rd_den(dp_rd_den),
        .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num),
        .out_den(out_den), .out_index(out_index), .out_last(out_last),
        .done(done), .singular(singular), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // datapath model controls
    int done_delay = 10;
    int sing_idx   = -1;
    int dcnt       = 0;

    // monitor records
    int cyc = 0;
    int wr_addr_q[$];
    int wr_data_q[$];
    int res_num_q[$];
    int res_den_q[$];
    int res_idx_q[$];
    int res_last_q[$];
    int start_cnt = 0;
    int done_cnt  = 0;
    int valid_cnt = 0;
    int start_cyc = 0;
    int te_cyc    = 0;
    bit te_seen   = 0;
    int sing_first = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: registered read port, dp_done after done_delay cycles of WAIT.
    always @(posedge clk) begin
        dp_rd_num <= 32'(100 + int'(dp_addr));
        dp_rd_den <= (int'(dp_addr) == sing_idx) ? 32'd0 : 32'd1;
        dp_done   <= 1'b0;
        if (dp_start) begin
            dcnt <= 1;
        end else if (dcnt > 0) begin
            if (done_delay == 0) begin
                dcnt <= dcnt + 1;
            end else if (dcnt == done_delay) begin
                dp_done <= 1'b1;
                dcnt    <= 0;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    // Mid-cycle monitor of DUT activity.
    always @(negedge clk) begin
        if (reset) begin
            if (dp_wr_en) begin
                wr_addr_q.push_back(int'(dp_addr));
                wr_data_q.push_back(int'(dp_wdata));
            end
            if (dp_start) begin
                start_cnt = start_cnt + 1;
                start_cyc = cyc;
            end
            if (out_valid) valid_cnt = valid_cnt + 1;
            if (out_valid && out_ready) begin
                res_num_q.push_back(int'(out_num));
                res_den_q.push_back(int'(out_den));
                res_idx_q.push_back(int'(out_index));
                res_last_q.push_back(int'(out_last));
            end
            if (done) done_cnt = done_cnt + 1;
            if (timeout_err && !te_seen) begin
                te_seen = 1;
                te_cyc  = cyc;
            end
            if (singular && out_valid && sing_first < 0) sing_first = int'(out_index);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_records();
        wr_addr_q.delete();
        wr_data_q.delete();
        res_num_q.delete();
        res_den_q.delete();
        res_idx_q.delete();
        res_last_q.delete();
        start_cnt  = 0;
        done_cnt   = 0;
        valid_cnt  = 0;
        te_seen    = 0;
        sing_first = -1;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_load_ready"}, 32'(load_ready), 0);
        chk({pfx, "_dp_wr_en"}, 32'(dp_wr_en), 0);
        chk({pfx, "_dp_addr"}, 32'(dp_addr), 0);
        chk({pfx, "_dp_wdata"}, dp_wdata, 0);
        chk({pfx, "_dp_start"}, 32'(dp_start), 0);
        chk({pfx, "_out_valid"}, 32'(out_valid), 0);
        chk({pfx, "_out_num"}, out_num, 0);
        chk({pfx, "_out_den"}, out_den, 0);
        chk({pfx, "_out_index"}, 32'(out_index), 0);
        chk({pfx, "_out_last"}, 32'(out_last), 0);
        chk({pfx, "_done"}, 32'(done), 0);
        chk({pfx, "_singular"}, 32'(singular), 0);
        chk({pfx, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    // One job: start, load 1..25, optional stall/start-poke, then drain.
    // bp_idx/bp_len hold out_ready low on one result; abort_idx pulls reset
    // when that result is first offered.
    task automatic run_job(input int delay, input bit stall, input int bp_idx,
                           input int bp_len, input bit poke_start, input int abort_idx);
        int  guard;
        int  held;
        bit  fin;
        clear_records();
        done_delay = delay;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clears_singular", 32'(singular), 0);
        chk("start_clears_timeout", 32'(timeout_err), 0);
        for (int i = 0; i < NELEM; i++) begin
            if (stall) begin
                load_valid = 1'b0;
                tick();
            end
            guard = 0;
            while (!load_ready && guard < 50) begin
                tick();
                guard++;
            end
            load_valid = 1'b1;
            load_data  = 32'(i + 1);
            tick();
        end
        load_valid = 1'b0;
        load_data  = '0;
        if (poke_start) begin
            tick();
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        held  = 0;
        fin   = 0;
        guard = 0;
        out_ready = 1'b1;
        while (!fin && guard < 3000) begin
            if (abort_idx >= 0 && out_valid && int'(out_index) == abort_idx) begin
                reset = 1'b0;
                #1;
                check_all_zero("abort");
                repeat (3) tick();
                chk("abort_no_done", 32'(done_cnt), 0);
                fin = 1;
            end else begin
                if (out_valid && int'(out_index) == bp_idx && held < bp_len) begin
                    chk($sformatf("bp_num_%0d", held), out_num, 32'(100 + bp_idx));
                    chk($sformatf("bp_den_%0d", held), out_den, 1);
                    chk($sformatf("bp_idx_%0d", held), 32'(out_index), 32'(bp_idx));
                    out_ready = 1'b0;
                    held++;
                end else begin
                    out_ready = 1'b1;
                end
                tick();
                guard++;
                if (done) fin = 1;
            end
        end
        chk("job_finished_in_bound", 32'(fin), 1);
        if (abort_idx < 0) begin
            tick();
            chk("busy_low_after_job", 32'(busy), 0);
        end
    endtask

    task automatic check_loads();
        chk("wr_count", 32'(wr_addr_q.size()), 25);
        for (int k = 0; k < wr_addr_q.size() && k < NELEM; k++) begin
            chk($sformatf("wr_addr_%0d", k), 32'(wr_addr_q[k]), 32'(k));
            chk($sformatf("wr_data_%0d", k), 32'(wr_data_q[k]), 32'(k + 1));
        end
        chk("dp_start_count", 32'(start_cnt), 1);
    endtask

    task automatic check_results(input int sing);
        chk("res_count", 32'(res_idx_q.size()), 25);
        for (int k = 0; k < res_idx_q.size() && k < NELEM; k++) begin
            chk($sformatf("res_idx_%0d", k), 32'(res_idx_q[k]), 32'(k));
            chk($sformatf("res_num_%0d", k), 32'(res_num_q[k]), 32'(100 + k));
            chk($sformatf("res_den_%0d", k), 32'(res_den_q[k]), (k == sing) ? 32'd0 : 32'd1);
            chk($sformatf("res_last_%0d", k), 32'(res_last_q[k]), (k == 24) ? 32'd1 : 32'd0);
        end
        chk("done_count", 32'(done_cnt), 1);
        chk("singular_flag", 32'(singular), (sing >= 0) ? 32'd1 : 32'd0);
        chk("timeout_flag", 32'(timeout_err), 0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // full job, no stalls
        run_job(10, 0, -1, 0, 0, -1);
        check_loads();
        check_results(-1);

        // load stream toggling valid every cycle
        run_job(10, 1, -1, 0, 0, -1);
        check_loads();
        check_results(-1);

        // backpressure at idx 3 for 7 cycles
        run_job(10, 0, 3, 7, 0, -1);
        check_loads();
        check_results(-1);

        // zero denominator at idx 12
        sing_idx = 12;
        run_job(10, 0, -1, 0, 0, -1);
        sing_idx = -1;
        check_results(12);
        chk("singular_first_idx", 32'(sing_first), 12);

        // next job clears singular; start poked during WAIT is ignored
        run_job(10, 0, -1, 0, 1, -1);
        check_loads();
        check_results(-1);

        // datapath never completes
        run_job(0, 0, -1, 0, 0, -1);
        check_loads();
        chk("to_timeout_err", 32'(timeout_err), 1);
        chk("to_latency", 32'(te_cyc - start_cyc), 32'(TMO + 1));
        chk("to_no_valid", 32'(valid_cnt), 0);
        chk("to_done_count", 32'(done_cnt), 1);

        // dp_done on the last WAIT cycle beats the timeout
        run_job(TMO - 1, 0, -1, 0, 0, -1);
        check_loads();
        check_results(-1);

        // reset while result 5 is offered
        run_job(10, 0, -1, 0, 0, 5);
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        check_all_zero("post_abort");

        // fresh job after abort
        run_job(10, 0, -1, 0, 0, -1);
        check_loads();
        check_results(-1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
